// File: rtl/cipher_round_ctrl_pkg.sv
// Shared AES-128 cipher definitions for the round controller.
// Holds the state and round-key types, the round count, the FSM state encoding,
// the S-box table and the round transforms used by the round datapath.
// The state is a packed 4x4 byte array. Byte k of a 128-bit block (bits [127-8k -: 8])
// is column k/4, row k%4. It is stored at packed index [3-k/4][3-k%4], so a 128-bit
// block assigns straight into the state without any reordering.
package cipher_round_ctrl_pkg;

   localparam int unsigned Nr = 10;
   localparam int unsigned Nb = 4;

   typedef logic [3:0][3:0][7:0] state_t;
   typedef logic [127:0]         rkey_t;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRound,
      StFinal,
      StDone
   } fsm_state_e;

   localparam logic [7:0] Sbox [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic state_t sub_bytes(state_t s);
      state_t o;
      o = '0;
      for (int i = 0; i < int'(Nb); i++) begin
         for (int j = 0; j < 4; j++) begin
            o[2'(i)][2'(j)] = Sbox[s[2'(i)][2'(j)]];
         end
      end
      return o;
   endfunction

   // Row r rotates left by r columns: out(col c, row r) = in(col (c+r)%4, row r).
   function automatic state_t shift_rows(state_t s);
      state_t o;
      o = '0;
      for (int c = 0; c < int'(Nb); c++) begin
         for (int r = 0; r < 4; r++) begin
            o[2'(3 - c)][2'(3 - r)] = s[2'(3 - ((c + r) % 4))][2'(3 - r)];
         end
      end
      return o;
   endfunction

   function automatic state_t mix_columns(state_t s);
      state_t     o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < int'(Nb); c++) begin
         // Row 0 of a column sits at the highest packed index.
         a0 = s[2'(3 - c)][3];
         a1 = s[2'(3 - c)][2];
         a2 = s[2'(3 - c)][1];
         a3 = s[2'(3 - c)][0];
         o[2'(3 - c)][3] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[2'(3 - c)][2] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[2'(3 - c)][1] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[2'(3 - c)][0] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic state_t add_round_key(state_t s, rkey_t k);
      return s ^ k;
   endfunction

endpackage

// File: rtl/cipher_round_ctrl_round.sv
// One AES encryption round, purely combinational (the cipherRound block).
// Ports:
//   i_state - current cipher state
//   i_key   - round key applied by AddRoundKey
//   i_final - 1 for the last round, which skips MixColumns
//   o_state - state after SubBytes, ShiftRows, [MixColumns], AddRoundKey
module cipher_round_ctrl_round
   import cipher_round_ctrl_pkg::*;
(
   input  state_t i_state,
   input  rkey_t  i_key,
   input  logic   i_final,
   output state_t o_state
);

   state_t w_sub;
   state_t w_shift;
   state_t w_mix;

   assign w_sub   = sub_bytes(i_state);
   assign w_shift = shift_rows(w_sub);
   assign w_mix   = i_final ? w_shift : mix_columns(w_shift);
   assign o_state = add_round_key(w_mix, i_key);

endmodule

// File: rtl/cipher_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock.
// The round keys come from an external synchronous key store, so each round key is
// requested one cycle before the round that consumes it. The latency from accept to
// out_valid is fixed at 12 cycles.
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    - plaintext handshake, in_ready high only when idle
//   in_data              - plaintext block
//   rk_addr/rk_data      - round-key index out, key back one cycle later
//   out_valid/out_ready  - ciphertext handshake, held under back-pressure
//   out_data             - ciphertext, which is always the state register
//   busy                 - high whenever not idle
module cipher_round_ctrl
   import cipher_round_ctrl_pkg::*;
#(
   parameter int unsigned NR = Nr  // only 10 is supported
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   rk_addr,
   input  logic [127:0] rk_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   fsm_state_e r_fsm;
   logic [3:0] r_rnd;
   state_t     r_state;
   logic       r_in_ready;
   logic       r_out_valid;
   logic       r_busy;
   logic [3:0] r_rk_addr;

   state_t     w_round_state;
   logic       w_final;

   assign w_final = (r_fsm == StFinal);

   cipher_round_ctrl_round u_round (
      .i_state (r_state),
      .i_key   (rk_data),
      .i_final (w_final),
      .o_state (w_round_state)
   );

   // All outputs are registered. Each one is set on the transition into the state
   // where it must hold. rk_addr is the key index that the next state consumes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm       <= StIdle;
         r_rnd       <= '0;
         r_state     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_rk_addr   <= '0;
      end else begin
         unique case (r_fsm)
            StIdle: begin
               if (in_valid) begin
                  r_state    <= in_data;
                  r_rnd      <= '0;
                  r_fsm      <= StLoad;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_rk_addr  <= 4'd1;
               end
            end
            StLoad: begin
               // Initial AddRoundKey with key 0.
               r_state   <= add_round_key(r_state, rk_data);
               r_rnd     <= 4'd1;
               r_fsm     <= StRound;
               r_rk_addr <= 4'd2;
            end
            StRound: begin
               r_state <= w_round_state;
               r_rnd   <= r_rnd + 4'd1;
               if (r_rnd == 4'(NR - 1)) begin
                  r_fsm     <= StFinal;
                  r_rk_addr <= 4'd0;
               end else begin
                  r_rk_addr <= r_rnd + 4'd2;
               end
            end
            StFinal: begin
               r_state     <= w_round_state;
               r_fsm       <= StDone;
               r_out_valid <= 1'b1;
            end
            StDone: begin
               if (out_ready) begin
                  r_fsm       <= StIdle;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_fsm       <= StIdle;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_rk_addr   <= '0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign rk_addr   = r_rk_addr;
   assign out_data  = r_state;

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Directed bench for cipher_round_ctrl. It uses the FIPS-197 App. B and C.1 vectors,
// a synchronous round-key store model, back-pressure, busy-time input, a mid-round
// reset and back-to-back blocks.
module tb_cipher_round_ctrl;
   import cipher_round_ctrl_pkg::*;

   localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_addr;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   logic [127:0] ks [16];
   int           n_total;
   int           n_bad;
   int           cyc;

   cipher_round_ctrl #(.NR(10)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_addr   (rk_addr),
      .rk_data   (rk_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key store: synchronous read, one-cycle latency.
   always @(posedge clk) rk_data <= ks[rk_addr];

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // AES-128 key expansion into the key store.
   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {Sbox[t[31:24]], Sbox[t[23:16]], Sbox[t[15:8]], Sbox[t[7:0]]};
            t[31:24] = t[31:24] ^ rcon;
            rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int r = 0; r < 11; r++) ks[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endtask

   // Accept one block and return the cycle count from accept to out_valid (bounded).
   task automatic send_and_wait(input logic [127:0] pt, output int lat);
      chk("send in_ready", 128'(in_ready), 128'(1));
      in_data  = pt;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   initial begin
      int           lat;
      int           acc1;
      int           acc2;
      int           out1;
      int           n_out;
      logic [127:0] exp_ct [2];

      n_total = 0;
      n_bad   = 0;
      cyc     = 0;
      for (int i = 0; i < 16; i++) ks[i] = '0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state.
      step();
      step();
      chk("rst out_valid", 128'(out_valid), 128'(0));
      chk("rst busy", 128'(busy), 128'(0));
      chk("rst rk_addr", 128'(rk_addr), 128'(0));
      chk("rst out_data", out_data, 128'(0));
      rst = 1'b0;
      step();
      chk("idle in_ready", 128'(in_ready), 128'(1));
      chk("idle busy", 128'(busy), 128'(0));

      // App. B, then hold out_ready low for 5 cycles.
      expand(KeyB);
      send_and_wait(PtB, lat);
      chk("B latency", 128'(lat), 128'(12));
      chk("B out_data", out_data, CtB);
      for (int i = 1; i <= 5; i++) begin
         chk("bp out_valid", 128'(out_valid), 128'(1));
         chk("bp out_data", out_data, CtB);
         chk("bp in_ready", 128'(in_ready), 128'(0));
         step();
      end
      chk("bp c6 out_valid", 128'(out_valid), 128'(1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp c7 in_ready", 128'(in_ready), 128'(1));
      chk("bp c7 out_valid", 128'(out_valid), 128'(0));

      // App. C.1 with rk_addr trace, in_valid held high with changing data while busy.
      expand(KeyC);
      in_data  = PtC;
      in_valid = 1'b1;
      chk("C1 in_ready", 128'(in_ready), 128'(1));
      for (int i = 0; i <= 11; i++) begin
         chk("C1 rk_addr", 128'(rk_addr), 128'((i == 11) ? 0 : i));
         chk("C1 early out_valid", 128'(out_valid), 128'(0));
         step();
         in_data = {4{32'(i) ^ 32'h5a5a_0000}};
      end
      chk("C1 out_valid", 128'(out_valid), 128'(1));
      chk("C1 out_data", out_data, CtC);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("C1 in_ready after", 128'(in_ready), 128'(1));
      chk("C1 busy after", 128'(busy), 128'(0));

      // Reset at rnd=5 (cycle accept+6), then a clean App. B block.
      expand(KeyB);
      in_data  = PtB;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      chk("mid rk_addr", 128'(rk_addr), 128'(6));
      chk("mid busy", 128'(busy), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("arst busy", 128'(busy), 128'(0));
      chk("arst out_valid", 128'(out_valid), 128'(0));
      chk("arst rk_addr", 128'(rk_addr), 128'(0));
      chk("arst out_data", out_data, 128'(0));
      rst = 1'b0;
      step();
      chk("post rst in_ready", 128'(in_ready), 128'(1));
      out_ready = 1'b1;
      send_and_wait(PtB, lat);
      chk("post rst latency", 128'(lat), 128'(12));
      chk("post rst out_data", out_data, CtB);
      step();
      chk("post rst idle", 128'(in_ready), 128'(1));

      // Back-to-back blocks: key store switched to key C between the two blocks.
      exp_ct[0] = CtB;
      exp_ct[1] = CtC;
      in_data   = PtB;
      in_valid  = 1'b1;
      n_out     = 0;
      acc1      = -1;
      acc2      = -1;
      out1      = -1;
      for (int i = 0; i < 40 && n_out < 2; i++) begin
         if (in_ready && in_valid) begin
            if (acc1 < 0) acc1 = cyc;
            else acc2 = cyc;
         end
         if (out_valid) begin
            chk("b2b out_data", out_data, exp_ct[n_out]);
            if (n_out == 0) begin
               out1 = cyc;
               expand(KeyC);
               in_data = PtC;
            end else begin
               in_valid = 1'b0;
            end
            n_out++;
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("b2b outputs", 128'(n_out), 128'(2));
      chk("b2b accept gap", 128'(acc2 - acc1), 128'(13));
      chk("b2b latency", 128'(out1 - acc1), 128'(12));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/cipher_round_ctrl.md
CIPHER_ROUND_CTRL -- requirements
Module: cipher_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of cipher rounds (AES-128); only the value 10 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the plaintext block on in_data is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a plaintext.
REQ-006 SHALL have port in_data, input, 128 bits: the plaintext; byte k is bits [127-8k -: 8] and maps to state[k/4][k%4].
REQ-007 SHALL have port rk_addr, output, 4 bits: round-key index presented to the external key store.
REQ-008 SHALL have port rk_data, input, 128 bits: round key for the rk_addr value of the previous cycle (synchronous read, 1-cycle latency), with the same byte mapping as in_data.
REQ-009 SHALL have port out_valid, output, 1 bit: the ciphertext on out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the ciphertext.
REQ-011 SHALL have port out_data, output, 128 bits: the ciphertext, with the same byte mapping as in_data.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, ROUND, FINAL, DONE, plus a 4-bit round counter rnd.
REQ-014 in_ready SHALL be 1 only in IDLE; an accept occurs when in_valid=1 and in_ready=1 on the same edge.
REQ-015 in_valid SHALL be ignored in every state other than IDLE; no input is queued.
REQ-016 rk_addr SHALL be 0 in IDLE and DONE, 1 in LOAD, rnd+1 in ROUND, and 0 in FINAL.
REQ-017 On accept in cycle T: state register <= in_data; FSM -> LOAD.
REQ-018 LOAD (cycle T+1): state <= state XOR rk_data (key 0); rnd <= 1; FSM -> ROUND.
REQ-019 ROUND (cycles T+2..T+10): state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk_data); rnd increments each cycle.
REQ-020 ROUND SHALL move to FINAL after the cycle in which rnd = NR-1.
REQ-021 FINAL (cycle T+11): state <= AddRoundKey(ShiftRows(SubBytes(state)), rk_data), with no MixColumns; FSM -> DONE.
REQ-022 DONE: out_valid=1 from cycle T+12, giving a fixed latency of 12 cycles from accept to out_valid.
REQ-023 out_data SHALL be stable while out_valid=1 and out_ready=0; DONE is held indefinitely under back-pressure.
REQ-024 On out_valid=1 and out_ready=1: FSM -> IDLE, and in_ready=1 on the next cycle.
REQ-025 The minimum interval between accepts SHALL be 13 cycles.
REQ-026 out_valid SHALL be 0 outside DONE.
REQ-027 out_data SHALL always equal the state register.
REQ-028 rnd SHALL never exceed NR; rnd is not used outside ROUND.

Reset
REQ-029 On rst=1, regardless of clk, the FSM SHALL enter IDLE and rnd and the state register SHALL clear to 0.
REQ-030 During and after reset, outputs SHALL be: in_ready=1 once rst=0, out_valid=0, busy=0, rk_addr=0, out_data=0.
REQ-031 Reset in any state, including mid-ROUND or DONE, SHALL discard the block in flight with no partial output.

Structure
REQ-032 The shared Cipher package SHALL hold the state type (4x4 array of 8-bit bytes), the round-key type, NR=10, Nb=4, and the FSM state enumeration.
REQ-033 One combinational sub-module, cipherRound, SHALL be used: inputs state, key, final flag; output next state. It composes the existing subBytes, shiftRows, mixColumns and addRoundKey blocks, and skips MixColumns when final=1.
REQ-034 cipher_round_ctrl SHALL contain only the FSM, the counter, the state register and the handshake logic.

Verification
REQ-035 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c (round keys from the bench key-store model), plaintext 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32 with out_valid at accept+12.
REQ-036 FIPS-197 App. C.1: key 000102...0f, plaintext 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; the rk_addr trace from the accept cycle onward is 0,1,2,...,10,0.
REQ-037 Back-pressure: out_ready=0 for 5 cycles after out_valid -> out_data and out_valid held unchanged; the handshake on cycle 6 is followed by in_ready=1 on cycle 7.
REQ-038 in_valid held at 1 with changing in_data while busy -> no second accept, and the first ciphertext is unaffected.
REQ-039 rst asserted mid-ROUND (rnd=5) -> busy=0, out_valid=0, rk_addr=0 immediately; the next App. B block still produces the correct result.
REQ-040 Two back-to-back blocks with out_ready=1 -> accepts exactly 13 cycles apart, and both ciphertexts correct.
